// File: rtl/slave_port_burst.sv
// slave_port_burst: serial-bus slave port with burst support.
// Receives mode, address and burst length serially (LSB first), then runs
// len+1 consecutive write or read beats against slave memory with an
// auto-incrementing, wrapping address. Reads may optionally use a split
// transaction on the first beat.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for first header bit (mode + addr[0])
// ADDR    | shifting in addr[1..ADDR_WIDTH-1]
// LEN     | shifting in burst length field
// WDATA   | shifting in one write data word
// MWRITE  | single-cycle memory write, then advance address / beat
// MREAD   | memory read request held until rvalid
// SPLIT   | first read beat of a split burst: latency count + capture
// WAIT    | split read data held, waiting for split_grant
// RDATA   | serialising rbuf to the master, two cycles per bit
module slave_port_burst #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int LEN_WIDTH     = 4,
  parameter int SPLIT_EN      = 0,
  parameter int SPLIT_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] smemrdata,
  input  logic                  rvalid,
  output logic                  smemwen,
  output logic                  smemren,
  output logic [ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0] smemwdata,
  input  logic                  swdata,
  output logic                  srdata,
  input  logic                  smode,
  input  logic                  mvalid,
  input  logic                  split_grant,
  output logic                  svalid,
  output logic                  sready,
  output logic                  ssplit
);

  // One shared down-counter serves every serial field, the RDATA bit count
  // and the split latency; it must hold the largest of these terminal values.
  localparam int CNT_M1 = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_M2 = (CNT_M1 > LEN_WIDTH) ? CNT_M1 : LEN_WIDTH;
  localparam int CNT_M3 = (CNT_M2 > SPLIT_LATENCY) ? CNT_M2 : SPLIT_LATENCY;
  localparam int CNT_W  = $clog2(CNT_M3 + 1);

  localparam logic [CNT_W-1:0]      CNT_ZERO = '0;
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ADDR = CNT_W'(ADDR_WIDTH - 2);
  localparam logic [CNT_W-1:0]      CNT_LEN  = CNT_W'(LEN_WIDTH - 1);
  localparam logic [CNT_W-1:0]      CNT_DATA = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]      CNT_LAT  = CNT_W'(SPLIT_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  BEAT_ONE = LEN_WIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ADDR   = 4'd1,
    S_LEN    = 4'd2,
    S_WDATA  = 4'd3,
    S_MWRITE = 4'd4,
    S_MREAD  = 4'd5,
    S_SPLIT  = 4'd6,
    S_WAIT   = 4'd7,
    S_RDATA  = 4'd8
  } state_t;

  state_t                state, state_nxt;
  logic                  mode, mode_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [LEN_WIDTH-1:0]  len, len_nxt;
  logic [LEN_WIDTH-1:0]  beat, beat_nxt;
  logic [DATA_WIDTH-1:0] wdata, wdata_nxt;
  logic [DATA_WIDTH-1:0] rbuf, rbuf_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  phase, phase_nxt;
  logic                  got, got_nxt;

  logic                  smemwen_nxt;
  logic                  smemren_nxt;
  logic [ADDR_WIDTH-1:0] smemaddr_nxt;
  logic [DATA_WIDTH-1:0] smemwdata_nxt;
  logic                  srdata_nxt;
  logic                  svalid_nxt;

  // Serial fields shift in from the MSB end, so after a full field the
  // first (LSB) bit has landed at bit 0 and stale contents are gone.
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic [LEN_WIDTH-1:0]  len_shift;
  logic [DATA_WIDTH-1:0] wdata_shift;

  assign addr_shift  = ADDR_WIDTH'({swdata, addr} >> 1);
  assign len_shift   = LEN_WIDTH'({swdata, len} >> 1);
  assign wdata_shift = DATA_WIDTH'({swdata, wdata} >> 1);

  // State, datapath and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      mode      <= 1'b0;
      addr      <= '0;
      len       <= '0;
      beat      <= '0;
      wdata     <= '0;
      rbuf      <= '0;
      cnt       <= '0;
      phase     <= 1'b0;
      got       <= 1'b0;
      smemwen   <= 1'b0;
      smemren   <= 1'b0;
      smemaddr  <= '0;
      smemwdata <= '0;
      srdata    <= 1'b0;
      svalid    <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode      <= mode_nxt;
      addr      <= addr_nxt;
      len       <= len_nxt;
      beat      <= beat_nxt;
      wdata     <= wdata_nxt;
      rbuf      <= rbuf_nxt;
      cnt       <= cnt_nxt;
      phase     <= phase_nxt;
      got       <= got_nxt;
      smemwen   <= smemwen_nxt;
      smemren   <= smemren_nxt;
      smemaddr  <= smemaddr_nxt;
      smemwdata <= smemwdata_nxt;
      srdata    <= srdata_nxt;
      svalid    <= svalid_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    addr_nxt  = addr;
    len_nxt   = len;
    beat_nxt  = beat;
    wdata_nxt = wdata;
    rbuf_nxt  = rbuf;
    cnt_nxt   = cnt;
    phase_nxt = phase;
    got_nxt   = got;
    case (state)
      S_IDLE: begin
        if (mvalid) begin
          mode_nxt  = smode;
          addr_nxt  = addr_shift;
          cnt_nxt   = CNT_ADDR;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (mvalid) begin
          addr_nxt = addr_shift;
          if (cnt == CNT_ZERO) begin
            cnt_nxt   = CNT_LEN;
            state_nxt = S_LEN;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
      end
      S_LEN: begin
        if (mvalid) begin
          len_nxt = len_shift;
          if (cnt == CNT_ZERO) begin
            beat_nxt  = '0;
            got_nxt   = 1'b0;
            phase_nxt = 1'b0;
            if (mode) begin
              cnt_nxt   = CNT_DATA;
              state_nxt = S_WDATA;
            end else if (SPLIT_EN != 0) begin
              cnt_nxt   = CNT_LAT;
              state_nxt = S_SPLIT;
            end else begin
              state_nxt = S_MREAD;
            end
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
      end
      S_WDATA: begin
        if (mvalid) begin
          wdata_nxt = wdata_shift;
          if (cnt == CNT_ZERO) begin
            state_nxt = S_MWRITE;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
      end
      S_MWRITE: begin
        addr_nxt = addr + ADDR_ONE;
        if (beat == len) begin
          state_nxt = S_IDLE;
        end else begin
          beat_nxt  = beat + BEAT_ONE;
          cnt_nxt   = CNT_DATA;
          state_nxt = S_WDATA;
        end
      end
      S_MREAD: begin
        if (rvalid) begin
          rbuf_nxt  = smemrdata;
          cnt_nxt   = CNT_DATA;
          phase_nxt = 1'b0;
          state_nxt = S_RDATA;
        end
      end
      S_SPLIT: begin
        if (rvalid) begin
          rbuf_nxt = smemrdata;
          got_nxt  = 1'b1;
        end
        // Latency counter parks at zero until the read data has arrived.
        if (cnt == CNT_ZERO) begin
          if (rvalid || got) begin
            state_nxt = S_WAIT;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_WAIT: begin
        if (split_grant) begin
          cnt_nxt   = CNT_DATA;
          phase_nxt = 1'b0;
          state_nxt = S_RDATA;
        end
      end
      S_RDATA: begin
        if (!phase) begin
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          if (cnt == CNT_ZERO) begin
            addr_nxt = addr + ADDR_ONE;
            if (beat == len) begin
              state_nxt = S_IDLE;
            end else begin
              beat_nxt  = beat + BEAT_ONE;
              state_nxt = S_MREAD;
            end
          end else begin
            cnt_nxt  = cnt - CNT_ONE;
            rbuf_nxt = rbuf >> 1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode: sready/ssplit from the current state, the rest computed
  // from the next state so the registered outputs line up with it.
  always_comb begin
    sready        = (state == S_IDLE);
    ssplit        = (state == S_SPLIT);
    smemwen_nxt   = (state_nxt == S_MWRITE);
    smemren_nxt   = (state_nxt == S_MREAD) || (state_nxt == S_SPLIT);
    smemaddr_nxt  = smemaddr;
    smemwdata_nxt = smemwdata;
    srdata_nxt    = 1'b0;
    svalid_nxt    = 1'b0;
    if (smemwen_nxt || smemren_nxt) begin
      smemaddr_nxt = addr_nxt;
    end
    if (smemwen_nxt) begin
      smemwdata_nxt = wdata_nxt;
    end
    if (state_nxt == S_RDATA) begin
      srdata_nxt = rbuf_nxt[0];
      svalid_nxt = phase_nxt;
    end
  end

endmodule

// File: doc/slave_port_burst.md
# slave_port_burst

Serial-bus slave port with burst support, a successor to the single-beat slave port. It receives mode, address and a burst-length field serially from the master. It then runs 1..2^LEN_WIDTH consecutive beats against slave memory, either writes or reads, with the address auto-incrementing. It sits between the serial bus interconnect and a slave BRAM, and keeps the existing bus handshake (mvalid/svalid/sready/ssplit/split_grant).

## Interface
- ADDR_WIDTH, 12, slave memory address width
- DATA_WIDTH, 8, data word width
- LEN_WIDTH, 4, burst-length field width; beats = LEN+1
- SPLIT_EN, 0, 1 = reads use split transactions
- SPLIT_LATENCY, 4, minimum SPLIT cycles before WAIT (≥1)
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- smemrdata  input  DATA_WIDTH  memory read data
- rvalid  input  1  smemrdata valid
- smemwen  output  1  memory write enable
- smemren  output  1  memory read enable
- smemaddr  output  ADDR_WIDTH  memory address
- smemwdata  output  DATA_WIDTH  memory write data
- swdata  input  1  serial address/len/write-data bit from master
- srdata  output  1  serial read-data bit to master
- smode  input  1  0 read, 1 write; sampled with first address bit
- mvalid  input  1  swdata valid this cycle
- split_grant  input  1  bus granted for split read return
- svalid  output  1  srdata valid
- sready  output  1  high only in IDLE
- ssplit  output  1  high only in SPLIT

## Operation
- All serial fields are sent LSB first. One bit is sampled on every clk edge where mvalid=1 in IDLE/ADDR/LEN/WDATA. Cycles with mvalid=0 stall without losing state.
- States are IDLE, ADDR, LEN, WDATA, MWRITE, MREAD, SPLIT, WAIT, RDATA.
- IDLE, mvalid=1: latch mode=smode and addr[0]=swdata, then go to ADDR.
- ADDR: collect addr[1..ADDR_WIDTH-1], then go to LEN.
- LEN: collect LEN_WIDTH bits into len. Clear the beat counter. Go to WDATA if mode=1; otherwise go to SPLIT if SPLIT_EN, else MREAD.
- WDATA: collect DATA_WIDTH bits, then go to MWRITE.
- MWRITE: one cycle with smemwen=1, smemaddr=addr, smemwdata=wdata.
  - Then addr increments, wrapping from 2^ADDR_WIDTH-1 to 0.
  - If beat==len, go to IDLE; else beat+1 and go to WDATA.
- MREAD: smemren=1 with smemaddr=addr, held until rvalid=1. On rvalid, capture smemrdata into rbuf and go to RDATA.
- SPLIT (first read beat only): ssplit=1, smemren=1, latency counter runs, rbuf captured on rvalid. Exit to WAIT when the counter reaches SPLIT_LATENCY-1 and the data is captured (same-cycle rvalid counts).
- WAIT: smemren=0. When split_grant=1, go to RDATA. Later beats of the same burst use MREAD with no further split.
- RDATA: two cycles per bit.
  - Even phase: srdata=rbuf[i], svalid=0.
  - Odd phase: srdata held, svalid=1.
  - After bit DATA_WIDTH-1's odd phase: addr increments with wrap. If beat==len go to IDLE, else beat+1 and go to MREAD.
- smemwen and smemren are never high together.
- mvalid is ignored outside IDLE/ADDR/LEN/WDATA.
- split_grant is ignored outside WAIT.

## Timing
- All outputs are registered except sready and ssplit, which decode the state.
- Reset (rstn=0 at a clk edge):
  - state=IDLE, so sready=1 and ssplit=0;
  - smemwen=0, smemren=0, smemaddr=0, smemwdata=0, srdata=0, svalid=0;
  - all counters and buffers 0.
- Reset mid-burst aborts immediately. No partial write is issued after the reset edge.
- Header: 1+ADDR_WIDTH-1+LEN_WIDTH mvalid cycles.
- Write beat: DATA_WIDTH mvalid cycles, then 1 MWRITE cycle. The memory write occurs in the cycle after the last data bit is sampled.
- Read beat, non-split: MREAD of ≥1 cycle, then 2·DATA_WIDTH RDATA cycles. The first svalid=1 occurs 2 cycles after MREAD exits.
- Split: SPLIT lasts ≥SPLIT_LATENCY cycles. WAIT lasts ≥1 cycle. RDATA starts the cycle after split_grant is sampled.
- If rvalid arrives at the same edge the latency counter finishes, exit to WAIT.
- With len=2^LEN_WIDTH-1, exactly 2^LEN_WIDTH beats are performed.

## Test plan
- Single write: mode=1, addr=0x123, len=0, data=0xA5 → exactly one MWRITE pulse with smemaddr=0x123, smemwdata=0xA5, then sready=1.
- Burst write with wrap: addr=0xFFE, len=3, data 0x11,0x22,0x33,0x44 → writes to 0xFFE, 0xFFF, 0x000, 0x001 in order, with 4 smemwen pulses.
- Non-split read burst: SPLIT_EN=0, addr=0x010, len=1, memory returns 0x3C then 0xC3 with rvalid 2 cycles late → srdata bits LSB-first with svalid=1 on odd phases, 16 valid bits total, ssplit never high.
- Split read: SPLIT_EN=1, SPLIT_LATENCY=4, rvalid 6 cycles after SPLIT entry, split_grant asserted 3 cycles into WAIT → ssplit high for 6 cycles, RDATA starts the cycle after grant, word delivered correctly.
- mvalid gaps: random deassertion during header and write data → identical memory write to the gap-free case.
- Reset mid-WDATA and mid-RDATA → next cycle shows all outputs at reset values with sready=1. A following single write completes correctly.
